// File: rtl/distance_display_pkg.sv
// Shared types and helpers for the ultrasonic range display: FSM states,
// the 4-digit BCD value type, segment codes and BCD arithmetic.
package distance_display_pkg;

    typedef enum logic [1:0] {
        ST_TRIG,
        ST_WAIT,
        ST_MEAS,
        ST_HOLD
    } state_t;

    // Digit 3 is thousands, digit 0 is units.
    typedef logic [3:0][3:0] bcd_t;

    localparam bcd_t BCD_ZERO = 16'h0000;
    localparam bcd_t BCD_MAX  = 16'h9999;

    // Active-low segment codes, bit 0 = seg a ... bit 6 = seg g, bit 7 = dp.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Decimal increment that sticks at 9999 instead of rolling over.
    function automatic bcd_t bcd_inc_sat(input bcd_t value);
        bcd_t result;
        logic carry;
        result = value;
        carry  = (value != BCD_MAX);
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (result[i] == 4'd9) begin
                    result[i] = 4'd0;
                end else begin
                    result[i] = result[i] + 4'd1;
                    carry     = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/distance_display_scan.sv
// Four-digit multiplexed 7-segment driver: rotates a one-hot anode every
// SCAN_CYCLES clocks and registers the matching segment code alongside it.
module seven_seg_scan
    import distance_display_pkg::*;
#(
    parameter int SCAN_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  bcd_t       value,
    output logic [3:0] anode,
    output logic [7:0] cathode
);

    localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    sel;
    logic [1:0]    sel_next;
    logic          scan_wrap;

    assign scan_wrap = (scan_cnt == SCAN_LAST);
    assign sel_next  = scan_wrap ? sel + 2'd1 : sel;

    // Anode and cathode are both loaded from sel_next so they always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            sel      <= 2'd0;
            anode    <= 4'b0001;
            cathode  <= SEG_0;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            sel      <= sel_next;
            anode    <= 4'b0001 << sel_next;
            cathode  <= digit_to_seg(value[sel_next]);
        end
    end

endmodule

// File: rtl/distance_display.sv
// HC-SR04-style range finder: periodic trigger, echo timing straight into a
// BCD centimetre count, and a multiplexed 4-digit readout.
module distance_display
    import distance_display_pkg::*;
#(
    parameter int TRIG_CYCLES         = 400,
    parameter int CYCLES_PER_CM       = 2320,
    parameter int ECHO_TIMEOUT_CYCLES = 1600000,
    parameter int MEAS_PERIOD_CYCLES  = 2400000,
    parameter int SCAN_CYCLES         = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       echo_i,
    output logic       trigger_o,
    output logic [3:0] anode_o,
    output logic [7:0] cathode_o
);

    localparam int PW = (MEAS_PERIOD_CYCLES > 1) ? $clog2(MEAS_PERIOD_CYCLES) : 1;
    localparam int WW = (ECHO_TIMEOUT_CYCLES > 1) ? $clog2(ECHO_TIMEOUT_CYCLES) : 1;
    localparam int CW = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    localparam logic [PW-1:0] TRIG_LAST   = PW'(TRIG_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(MEAS_PERIOD_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] PRESC_LAST  = CW'(CYCLES_PER_CM - 1);

    state_t        state, state_next;
    logic [PW-1:0] period_cnt, period_next;
    logic [WW-1:0] wait_cnt, wait_next;
    logic [CW-1:0] presc, presc_next;
    bcd_t          acc, acc_next;
    bcd_t          disp, disp_next;

    logic echo_meta, echo_sync, echo_prev;
    logic echo_rise, echo_fall, period_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_meta <= echo_i;
            echo_sync <= echo_meta;
            echo_prev <= echo_sync;
        end
    end

    assign echo_rise  = echo_sync & ~echo_prev;
    assign echo_fall  = ~echo_sync & echo_prev;
    assign period_end = (period_cnt == PERIOD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_TRIG;
            period_cnt <= '0;
            wait_cnt   <= '0;
            presc      <= '0;
            acc        <= BCD_ZERO;
            disp       <= BCD_ZERO;
            trigger_o  <= 1'b0;
        end else begin
            state      <= state_next;
            period_cnt <= period_next;
            wait_cnt   <= wait_next;
            presc      <= presc_next;
            acc        <= acc_next;
            disp       <= disp_next;
            // One-cycle lag keeps trigger low in reset yet high for TRIG_CYCLES clocks.
            trigger_o  <= (state == ST_TRIG);
        end
    end

    always_comb begin
        state_next  = state;
        period_next = period_cnt + 1'b1;
        wait_next   = '0;
        presc_next  = presc;
        acc_next    = acc;
        disp_next   = disp;

        case (state)
            ST_TRIG: begin
                if (period_cnt == TRIG_LAST) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (echo_rise) begin
                    state_next = ST_MEAS;
                    presc_next = '0;
                    acc_next   = BCD_ZERO;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = ST_HOLD;
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            ST_MEAS: begin
                // echo_prev is high from the cycle after the rise through the
                // fall cycle, so exactly the pulse width in clocks is counted.
                if (echo_prev) begin
                    if (presc == PRESC_LAST) begin
                        presc_next = '0;
                        acc_next   = bcd_inc_sat(acc);
                    end else begin
                        presc_next = presc + 1'b1;
                    end
                end
                if (echo_fall) begin
                    disp_next  = acc_next;
                    state_next = ST_HOLD;
                end else if (period_end) begin
                    disp_next  = acc_next;
                    state_next = ST_TRIG;
                end
            end
            ST_HOLD: begin
                if (period_end) state_next = ST_TRIG;
            end
            default: state_next = ST_TRIG;
        endcase

        if (state_next == ST_TRIG && state != ST_TRIG) period_next = '0;
    end

    seven_seg_scan #(
        .SCAN_CYCLES(SCAN_CYCLES)
    ) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .value  (disp),
        .anode  (anode_o),
        .cathode(cathode_o)
    );

endmodule

// File: tb/tb_distance_display.sv
// Directed bench for distance_display with shortened timing parameters.
module tb_distance_display;

    localparam int T    = 8;
    localparam int CPCM = 2;
    localparam int TO   = 3000;
    localparam int P    = 20200;
    localparam int SCAN = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       echo = 1'b0;
    logic       trigger;
    logic [3:0] anode;
    logic [7:0] cathode;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [3:0] exp_an [3] = '{4'b0100, 4'b1000, 4'b0001};

    distance_display #(
        .TRIG_CYCLES        (T),
        .CYCLES_PER_CM      (CPCM),
        .ECHO_TIMEOUT_CYCLES(TO),
        .MEAS_PERIOD_CYCLES (P),
        .SCAN_CYCLES        (SCAN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .echo_i   (echo),
        .trigger_o(trigger),
        .anode_o  (anode),
        .cathode_o(cathode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_trig(input string tag, input logic level, input int limit,
                             output int t, output int k);
        k = 0;
        while (trigger !== level && k < limit) begin
            @(negedge clk);
            k++;
        end
        t = cyc;
        check(tag, trigger, level);
    endtask

    task automatic check_display(input string tag, input int d3, input int d2,
                                 input int d1, input int d0);
        int digits [4];
        int n;
        logic [3:0] want;
        digits = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            want = 4'b0001 << i;
            n = 0;
            while (anode !== want && n < 4 * SCAN + 4) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("%s_d%0d", tag, i), {anode, cathode}, {want, seg_tab[digits[i]]});
        end
    endtask

    initial begin
        int t1, t2, t3, t4, t5, k, w, n, tmp;
        logic [3:0] prev_an;

        // Reset state
        cycles(3);
        check("rst_trigger", trigger, 1'b0);
        check("rst_anode", anode, 4'b0001);
        check("rst_cathode", cathode, 8'hC0);

        // First trigger after release
        rst_n = 1'b1;
        wait_trig("trig1_rise", 1'b1, 4, t1, k);
        check("trig1_latency_ok", (k >= 1 && k <= 2), 1'b1);
        check("rel_anode", anode, 4'b0001);
        check("rel_cathode", cathode, 8'hC0);
        w = 0;
        while (trigger === 1'b1 && w < T + 10) begin
            @(negedge clk);
            w++;
        end
        check("trig1_width", w, T);

        // Anode rotation
        prev_an = anode;
        n = 0;
        while (anode === prev_an && n < 2 * SCAN) begin
            @(negedge clk);
            n++;
        end
        check("scan_first", anode, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            prev_an = anode;
            n = 0;
            while (anode === prev_an && n < 2 * SCAN) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("scan_step%0d", i), anode, exp_an[i]);
            check($sformatf("scan_dwell%0d", i), n, SCAN);
        end

        // 10 cm echo
        echo = 1'b1;
        cycles(10 * CPCM);
        echo = 1'b0;
        cycles(6);
        check_display("d0010", 0, 0, 1, 0);

        wait_trig("trig2_rise", 1'b1, P + 10, t2, k);
        check("period1", t2 - t1, P);

        // 1234.5 cm echo truncates to 1234
        wait_trig("trig2_fall", 1'b0, T + 4, tmp, k);
        cycles(2);
        echo = 1'b1;
        cycles(1234 * CPCM + CPCM / 2);
        echo = 1'b0;
        cycles(6);
        check_display("d1234", 1, 2, 3, 4);

        // No echo: timeout keeps the display and the schedule
        wait_trig("trig3_rise", 1'b1, P + 10, t3, k);
        check("period2", t3 - t2, P);
        cycles(T + TO + 20);
        check("timeout_trig_low", trigger, 1'b0);
        check_display("timeout_hold", 1, 2, 3, 4);
        wait_trig("trig4_rise", 1'b1, P + 10, t4, k);
        check("period3", t4 - t3, P);

        // Echo held through the whole period saturates at 9999
        wait_trig("trig4_fall", 1'b0, T + 4, tmp, k);
        cycles(1);
        echo = 1'b1;
        wait_trig("trig5_rise", 1'b1, P + 10, t5, k);
        check("period4", t5 - t4, P);
        wait_trig("trig5_fall", 1'b0, T + 4, tmp, k);
        echo = 1'b0;
        cycles(6);
        check_display("d9999", 9, 9, 9, 9);

        // Reset in the middle of a measurement
        echo = 1'b1;
        cycles(12);
        n = 0;
        while (anode !== 4'b0100 && n < 4 * SCAN + 4) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_trigger", trigger, 1'b0);
        check("midrst_anode", anode, 4'b0001);
        check("midrst_cathode", cathode, 8'hC0);
        cycles(3);
        echo = 1'b0;
        rst_n = 1'b1;
        wait_trig("trig6_rise", 1'b1, 4, tmp, k);
        check("trig6_latency_ok", (k >= 1 && k <= 2), 1'b1);
        check_display("d0000", 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
